// File: rtl/hamming_decoder_pkg.sv
// Shared definitions for the extended-Hamming encoder/decoder pair: width codes,
// per-width code/data sizes and the data-bit extraction helper.
package hamming_decoder_pkg;

    typedef enum logic [1:0] {
        CW8     = 2'b00,
        CW16    = 2'b01,
        CW32    = 2'b10,
        CW_RSVD = 2'b11
    } cw_width_e;

    localparam int N_CW8  = 8;
    localparam int N_CW16 = 16;
    localparam int N_CW32 = 32;
    localparam int K_CW8  = 4;
    localparam int K_CW16 = 11;
    localparam int K_CW32 = 26;
    localparam int SYN_W  = 5;

    typedef struct packed {
        logic [31:0]      cw;
        cw_width_e        width;
        logic [SYN_W-1:0] syn;
        logic             par;
    } s1_t;

    typedef struct packed {
        logic [31:0] data;
        logic        corr;
        logic        uncorr;
    } s2_t;

    function automatic logic [5:0] cw_n(input cw_width_e w);
        case (w)
            CW8:     return 6'(N_CW8);
            CW16:    return 6'(N_CW16);
            CW32:    return 6'(N_CW32);
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [5:0] cw_k(input cw_width_e w);
        case (w)
            CW8:     return 6'(K_CW8);
            CW16:    return 6'(K_CW16);
            CW32:    return 6'(K_CW32);
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [31:0] cw_mask(input cw_width_e w);
        case (w)
            CW8:     return 32'h0000_00FF;
            CW16:    return 32'h0000_FFFF;
            CW32:    return 32'hFFFF_FFFF;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Data positions ascend identically for every width, so extracting from a
    // codeword already masked to n bits leaves bits at and above k zero.
    function automatic logic [31:0] extract_data(input logic [31:0] cw);
        logic [31:0] d;
        int          j;
        d = '0;
        j = 0;
        for (int i = 3; i < 32; i++) begin
            if ((i & (i - 1)) != 0) begin
                d[j[4:0]] = cw[i[4:0]];
                j++;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome/overall-parity generator for a width-masked codeword.
module hamming_syndrome
    import hamming_decoder_pkg::*;
(
    input  logic [31:0]      codeword,
    input  cw_width_e        width,
    output logic [SYN_W-1:0] syndrome,
    output logic             parity
);

    logic [31:0] cw_m;

    assign cw_m   = codeword & cw_mask(width);
    assign parity = ^cw_m;

    always_comb begin
        syndrome = '0;
        for (int i = 1; i < 32; i++) begin
            if (cw_m[i]) syndrome = syndrome ^ i[SYN_W-1:0];
        end
    end

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage extended-Hamming SEC-DED decoder with valid/ready handshakes and
// saturating corrected/uncorrectable event counters.
module hamming_decoder
    import hamming_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  CODEWORD_WIDTH,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] data_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out,
    output logic        err_corrected,
    output logic        err_uncorrectable,
    output logic [15:0] corr_count,
    output logic [15:0] uncorr_count
);

    localparam int STAGES = 2;

    logic [STAGES:1]  vld_pipe;
    logic             s1_adv, s2_adv;
    cw_width_e        in_width;
    logic [SYN_W-1:0] in_syn;
    logic             in_par;
    s1_t              s1_q;
    s2_t              s2_d, s2_q;
    logic [31:0]      fixed;

    assign in_width = cw_width_e'(CODEWORD_WIDTH);

    hamming_syndrome u_syn (
        .codeword (data_in),
        .width    (in_width),
        .syndrome (in_syn),
        .parity   (in_par)
    );

    assign s2_adv   = !vld_pipe[2] || out_ready;
    assign s1_adv   = s2_adv || !vld_pipe[1];
    assign in_ready = s1_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) begin
                    s1_q.cw    <= data_in & cw_mask(in_width);
                    s1_q.width <= in_width;
                    s1_q.syn   <= in_syn;
                    s1_q.par   <= in_par;
                end
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) s2_q <= s2_d;
            end
        end
    end

    // Odd overall parity means a single error at position s (s=0 is the
    // parity bit itself); even parity with nonzero syndrome is a double error.
    always_comb begin
        fixed = s1_q.cw;
        s2_d  = '0;
        if (s1_q.width == CW_RSVD) begin
            s2_d.uncorr = 1'b1;
        end else begin
            if (s1_q.par) begin
                if ({1'b0, s1_q.syn} < cw_n(s1_q.width)) begin
                    fixed[s1_q.syn] = ~fixed[s1_q.syn];
                    s2_d.corr       = 1'b1;
                end else begin
                    s2_d.uncorr = 1'b1;
                end
            end else if (s1_q.syn != '0) begin
                s2_d.uncorr = 1'b1;
            end
            s2_d.data = extract_data(fixed);
        end
    end

    assign out_valid         = vld_pipe[2];
    assign data_out          = s2_q.data;
    assign err_corrected     = s2_q.corr;
    assign err_uncorrectable = s2_q.uncorr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (out_valid && out_ready) begin
            if (s2_q.corr && corr_count != 16'hFFFF)
                corr_count <= corr_count + 16'd1;
            if (s2_q.uncorr && uncorr_count != 16'hFFFF)
                uncorr_count <= uncorr_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: distance-based reference decoder plus a
// scoreboard checking every output transfer, stall stability and counters.
module tb_hamming_decoder;
    import hamming_decoder_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic        corr;
        logic        unc;
    } exp_t;

    logic        clk, rst;
    logic [1:0]  width_in;
    logic        in_valid, in_ready;
    logic [31:0] data_in;
    logic        out_valid, out_ready;
    logic [31:0] data_out;
    logic        err_corrected, err_uncorrectable;
    logic [15:0] corr_count, uncorr_count;

    int checks = 0;
    int errors = 0;

    exp_t        q[$];
    int          m_corr, m_unc;
    bit          stalled;
    logic [31:0] p_data;
    logic        p_c, p_u;

    hamming_decoder dut (
        .clk               (clk),
        .rst               (rst),
        .CODEWORD_WIDTH    (width_in),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .data_in           (data_in),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .data_out          (data_out),
        .err_corrected     (err_corrected),
        .err_uncorrectable (err_uncorrectable),
        .corr_count        (corr_count),
        .uncorr_count      (uncorr_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int nbits(input logic [1:0] wc);
        case (wc)
            2'b00:   return 8;
            2'b01:   return 16;
            2'b10:   return 32;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_p2(input int i);
        return (i & (i - 1)) == 0;
    endfunction

    // Reference encoder: data into non-power-of-two positions, then parity bits.
    function automatic logic [31:0] enc(input logic [31:0] d, input int n);
        logic [31:0] c;
        int j;
        c = '0;
        j = 0;
        for (int i = 1; i < n; i++)
            if (!is_p2(i)) begin c[i] = d[j]; j++; end
        for (int b = 0; (1 << b) < n; b++) begin
            logic p;
            p = 0;
            for (int i = 1; i < n; i++)
                if (((i >> b) & 1) != 0) p ^= c[i];
            c[1 << b] = p;
        end
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [31:0] raw(input logic [31:0] w, input int n);
        logic [31:0] d;
        int j;
        d = '0;
        j = 0;
        for (int i = 1; i < n; i++)
            if (!is_p2(i)) begin d[j] = w[i]; j++; end
        return d;
    endfunction

    // Nearest-codeword decode: valid word, one flip away, or neither.
    function automatic exp_t model(input logic [31:0] din, input logic [1:0] wc);
        exp_t e;
        int n;
        logic [31:0] w, t;
        e = '0;
        n = nbits(wc);
        if (n == 0) begin e.unc = 1; return e; end
        w = (n == 32) ? din : (din & ((32'd1 << n) - 32'd1));
        if (enc(raw(w, n), n) == w) begin e.data = raw(w, n); return e; end
        for (int i = 0; i < n; i++) begin
            t = w ^ (32'd1 << i);
            if (enc(raw(t, n), n) == t) begin
                e.data = raw(t, n);
                e.corr = 1;
                return e;
            end
        end
        e.data = raw(w, n);
        e.unc  = 1;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            m_corr  = 0;
            m_unc   = 0;
            stalled = 0;
        end else begin
            checks++;
            if (corr_count !== 16'(m_corr) || uncorr_count !== 16'(m_unc)) begin
                errors++;
                $display("FAIL counters got %0d/%0d want %0d/%0d", corr_count, uncorr_count, m_corr, m_unc);
            end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || data_out !== p_data || err_corrected !== p_c || err_uncorrectable !== p_u) begin
                    errors++;
                    $display("FAIL stall_hold got v=%b d=%h c=%b u=%b want v=1 d=%h c=%b u=%b",
                             out_valid, data_out, err_corrected, err_uncorrectable, p_data, p_c, p_u);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_output got d=%h want no output", data_out);
                end else begin
                    e = q.pop_front();
                    if (data_out !== e.data || err_corrected !== e.corr || err_uncorrectable !== e.unc) begin
                        errors++;
                        $display("FAIL out_word got d=%h c=%b u=%b want d=%h c=%b u=%b",
                                 data_out, err_corrected, err_uncorrectable, e.data, e.corr, e.unc);
                    end
                end
                if (err_corrected === 1'b1 && m_corr < 65535) m_corr++;
                if (err_uncorrectable === 1'b1 && m_unc < 65535) m_unc++;
            end
            stalled = out_valid && !out_ready;
            p_data  = data_out;
            p_c     = err_corrected;
            p_u     = err_uncorrectable;
            if (in_valid && in_ready) q.push_back(model(data_in, width_in));
        end
    end

    task automatic send(input logic [31:0] w, input logic [1:0] wc);
        bit acc;
        int budget;
        acc = 0;
        budget = 0;
        in_valid = 1;
        data_in  = w;
        width_in = wc;
        while (!acc && budget < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        in_valid = 0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got in_ready=0 want 1 within 100 cycles");
        end
    endtask

    task automatic lit(input logic [31:0] w, input logic [1:0] wc,
                       input logic [31:0] exp_d, input logic exp_c, input logic exp_u);
        exp_t m, want;
        want = '{data: exp_d, corr: exp_c, unc: exp_u};
        m = model(w, wc);
        checks++;
        if (m !== want) begin
            errors++;
            $display("FAIL model_pin got %h/%b/%b want %h/%b/%b", m.data, m.corr, m.unc, exp_d, exp_c, exp_u);
        end
        send(w, wc);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || data_out !== exp_d || err_corrected !== exp_c || err_uncorrectable !== exp_u) begin
            errors++;
            $display("FAIL latency2 got v=%b d=%h c=%b u=%b want v=1 d=%h c=%b u=%b",
                     out_valid, data_out, err_corrected, err_uncorrectable, exp_d, exp_c, exp_u);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    initial begin
        rst = 1;
        in_valid = 0;
        out_ready = 1;
        width_in = 2'b00;
        data_in = '0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_data", data_out, 32'd0);
        chk("reset_flags", {30'd0, err_corrected, err_uncorrectable}, 32'd0);
        chk("reset_counters", {corr_count, uncorr_count}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        chk("enc_pin_8", enc(32'h1, 8), 32'h0F);
        chk("enc_pin_16", enc(32'h7FF, 16), 32'hFFFF);
        chk("enc_pin_32", enc(32'h03FF_FFFF, 32), 32'hFFFF_FFFF);

        lit(32'h0F, 2'b00, 32'h1, 0, 0);
        lit(32'h2F, 2'b00, 32'h1, 1, 0);
        chk("corr_count_one", 32'(corr_count), 32'd1);
        lit(32'h0E, 2'b00, 32'h1, 1, 0);
        lit(32'h6F, 2'b00, 32'h7, 0, 1);
        chk("uncorr_count_one", 32'(uncorr_count), 32'd1);
        lit(32'hABCD_EF0F, 2'b00, 32'h1, 0, 0);
        lit(32'h0000_FFFF, 2'b01, 32'h7FF, 0, 0);
        lit(32'hFFFF_DFFF, 2'b01, 32'h7FF, 1, 0);
        lit(32'hFFFF_FFFF, 2'b10, 32'h03FF_FFFF, 0, 0);
        lit(32'hFFFF_FFFF, 2'b11, 32'h0, 0, 1);

        // Back-to-back mixed-width stream with out_ready toggling.
        fork
            begin
                send(enc(32'h5, 8), 2'b00);
                send(enc(32'h5A5, 16) ^ 32'h0000_0400, 2'b01);
                send(enc(32'h0123_4567, 32) ^ 32'h8000_0000, 2'b10);
                send(enc(32'hA, 8) ^ 32'h0000_0003, 2'b00);
                send(32'h1234_5678, 2'b11);
                send(enc(32'h02AA_AAAA, 32) ^ 32'h0001_0100, 2'b10);
                send(enc(32'h3, 8) ^ 32'h1, 2'b00);
                send(enc(32'h7FF, 16), 2'b01);
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(posedge clk);
                    #1;
                    out_ready = (c % 2) == 0;
                end
            end
        join
        out_ready = 1;
        repeat (4) @(posedge clk);
        #1;
        chk("stream_drained", 32'(q.size()), 32'd0);
        chk("stream_idle", 32'(out_valid), 32'd0);

        // Reset with words in flight and a stalled output.
        out_ready = 0;
        send(enc(32'h9, 8) ^ 32'h10, 2'b00);
        send(enc(32'h7, 8) ^ 32'h60, 2'b00);
        #3;
        rst = 1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_counters", {corr_count, uncorr_count}, 32'd0);
        chk("rst_data", data_out, 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        out_ready = 1;
        chk("in_ready_after_midrst", 32'(in_ready), 32'd1);
        send(enc(32'h1555, 16) ^ 32'h1, 2'b01);
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_drained", 32'(q.size()), 32'd0);
        chk("post_rst_corr", 32'(corr_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
